mb_clk_train_ctrl: RTL and testbench
====================================

MB_CLK_TRAIN_CTRL -- requirements
Module: mb_clk_train_ctrl

Interface
REQ-001 Parameter MAX_ATTEMPTS, default 3, total clock-pattern attempts per request (1..7).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, per-attempt watchdog limit in i_sys_clk cycles.
REQ-003 Ports, one per line (name, direction, width, meaning), SHALL be:
- i_sys_clk  in  1  sole clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  one-cycle start-training request.
- i_abort  in  1  cancel the current sequence.
- i_clk_gen_done  in  1  clock-generator done flag; asynchronous, from the local_ckp domain.
- i_rx_valid  in  1  partner receiver result strobe.
- i_rx_pass  in  1  receiver result, valid with i_rx_valid.
- o_start_clk_training  out  1  level to the clock generator.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle completion pulse.
- o_pass  out  1  sticky pass result.
- o_fail  out  1  sticky fail result.
- o_timeout  out  1  sticky watchdog flag.
- o_attempt_cnt  out  3  attempts started in the current or last sequence.

Function
REQ-004 i_clk_gen_done SHALL pass through a 2-flop synchronizer (gen_done_s) before any use, adding 2 cycles of latency.
REQ-005 FSM states SHALL be IDLE, START, WAIT_GEN, WAIT_RX, GAP, FINISH; all outputs registered.
REQ-006 IDLE: on i_req go to START next cycle; clear o_pass/o_fail/o_timeout/o_attempt_cnt on the same edge.
REQ-007 START: assert o_start_clk_training, increment o_attempt_cnt, clear the watchdog, go to WAIT_GEN.
REQ-008 WAIT_GEN: hold o_start_clk_training=1; on gen_done_s=1, drive it 0 on the next edge and go to WAIT_RX.
REQ-009 WAIT_RX: on i_rx_valid with i_rx_pass=1, go to FINISH with pass.
REQ-010 WAIT_RX: on i_rx_valid with i_rx_pass=0, go to GAP if o_attempt_cnt<MAX_ATTEMPTS, else go to FINISH with fail.
REQ-011 GAP: wait until gen_done_s=0 (generator cleared done on falling start), then go to START; this guarantees a fresh rising edge for the generator.
REQ-012 FINISH: pulse o_done for exactly 1 cycle, set o_pass or o_fail, return to IDLE; o_pass/o_fail/o_timeout SHALL hold until the next accepted i_req.
REQ-013 o_busy SHALL be 1 in every state except IDLE.
REQ-014 i_req outside IDLE SHALL be ignored; i_rx_valid outside WAIT_RX SHALL be ignored.
REQ-015 i_abort in any non-IDLE state SHALL force IDLE on the next edge with o_start_clk_training=0, no o_done, and results unchanged; i_abort SHALL win over a simultaneous i_rx_valid or gen_done_s.
REQ-016 o_attempt_cnt SHALL saturate at MAX_ATTEMPTS and never wrap.

Reset
REQ-017 While i_rst_n=0 at a clock edge: state=IDLE, synchronizer flops=0, all outputs 0; reset mid-sequence SHALL drop o_start_clk_training at that edge.

Configuration
REQ-018 With MB_CLK_TRAIN_TIMEOUT_EN defined, a per-attempt counter SHALL run in WAIT_GEN/WAIT_RX; on reaching TIMEOUT_CYCLES it SHALL go to FINISH with o_fail=1 and o_timeout=1, regardless of remaining attempts.
REQ-019 Without MB_CLK_TRAIN_TIMEOUT_EN, the counter SHALL be absent, o_timeout tied 0, and WAIT states SHALL wait indefinitely.

Structure
REQ-020 The state enum, MAX_ATTEMPTS/TIMEOUT_CYCLES defaults and the attempt-counter width SHALL live in shared package ucie_mb_clk_pkg.
REQ-021 The synchronizer SHALL be sub-module mb_sync_2ff; all other logic SHALL be inline.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Pass: i_req, then done 40 cycles later, then rx pass -> o_done pulse once, o_pass=1, o_attempt_cnt=1, start high from cycle 1 to done+3.
- Retry: rx fail on attempts 1 and 2, pass on attempt 3 -> 3 rising edges of o_start_clk_training, each after gen_done_s=0, o_pass=1, o_attempt_cnt=3.
- Exhaust: 3 rx fails -> o_fail=1, o_attempt_cnt=3, no 4th start edge.
- Abort: i_abort in WAIT_GEN together with done -> IDLE, start=0, no o_done.
- Timeout (macro on, TIMEOUT_CYCLES=16): done never arrives -> o_done at attempt cycle ~17, o_fail=o_timeout=1; with macro off, o_busy stays 1.
- Reset: i_rst_n=0 mid-WAIT_RX -> all outputs 0 next edge; i_req while busy -> ignored.

Source files
------------

// File: rtl/ucie_mb_clk_pkg.sv
// Shared definitions for the mainband clock-training controller:
// FSM state encoding, default parameter values and attempt-counter width.
package ucie_mb_clk_pkg;

  localparam int MAX_ATTEMPTS_DEF   = 3;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int ATT_CNT_W          = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_GEN = 3'd2,
    WAIT_RX  = 3'd3,
    GAP      = 3'd4,
    FINISH   = 3'd5
  } state_e;

  // Saturating increment: the attempt counter stops at the configured limit.
  function automatic logic [ATT_CNT_W-1:0] sat_inc(
    input logic [ATT_CNT_W-1:0] cnt,
    input logic [ATT_CNT_W-1:0] lim
  );
    if (cnt >= lim) begin
      return lim;
    end else begin
      return cnt + ATT_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mb_sync_2ff.sv
// Two-flop synchronizer bringing a level from another clock domain into
// the local clock domain. Synchronous active-low reset clears both stages.
module mb_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous level through two stages.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mb_clk_train_ctrl.sv
// Mainband clock-training sequencer: requests a clock pattern from the
// generator, waits for the partner receiver verdict and retries up to
// MAX_ATTEMPTS times. Optional per-attempt watchdog is built in when the
// macro MB_CLK_TRAIN_TIMEOUT_EN is defined; otherwise waits are unbounded
// and o_timeout is tied low.
module mb_clk_train_ctrl
  import ucie_mb_clk_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = MAX_ATTEMPTS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_abort,
  input  logic                 i_clk_gen_done,
  input  logic                 i_rx_valid,
  input  logic                 i_rx_pass,
  output logic                 o_start_clk_training,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_fail,
  output logic                 o_timeout,
  output logic [ATT_CNT_W-1:0] o_attempt_cnt
);

  localparam logic [ATT_CNT_W-1:0] MAX_ATT = ATT_CNT_W'(MAX_ATTEMPTS);

  logic                 w_gen_done_s;
  state_e               r_state, w_state_nxt;
  logic                 r_start, w_start_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_pass, w_pass_nxt;
  logic                 r_fail, w_fail_nxt;
  logic [ATT_CNT_W-1:0] r_att, w_att_nxt;
  logic                 r_fin_pass, w_fin_pass_nxt;
  logic                 w_wdog_hit;

  mb_sync_2ff u_gen_done_sync (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_clk_gen_done),
    .o_q     (w_gen_done_s)
  );

`ifdef MB_CLK_TRAIN_TIMEOUT_EN
  localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic              r_fin_to, w_fin_to_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_in_wait;

  assign w_in_wait  = (r_state == WAIT_GEN) || (r_state == WAIT_RX);
  assign w_wdog_hit = w_in_wait && (r_wdog == WDOG_LAST);

  // Watchdog counting and the sticky timeout flag; the counter restarts per attempt.
  always_comb begin
    w_wdog_nxt    = r_wdog;
    w_fin_to_nxt  = r_fin_to;
    w_timeout_nxt = r_timeout;
    if (r_state == START) begin
      w_wdog_nxt   = '0;
      w_fin_to_nxt = 1'b0;
    end else if (w_wdog_hit && !i_abort) begin
      w_fin_to_nxt = 1'b1;
    end else if (w_in_wait) begin
      w_wdog_nxt = r_wdog + WDOG_W'(1);
    end else begin
      w_wdog_nxt = r_wdog;
    end
    if ((r_state == IDLE) && i_req) begin
      w_timeout_nxt = 1'b0;
    end else if ((r_state == FINISH) && !i_abort) begin
      w_timeout_nxt = r_fin_to;
    end else begin
      w_timeout_nxt = r_timeout;
    end
  end

  // Watchdog registers.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_wdog    <= '0;
      r_fin_to  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_wdog    <= w_wdog_nxt;
      r_fin_to  <= w_fin_to_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_wdog_hit = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  // Next-state and next-output decode; abort overrides every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_nxt    = r_start;
    w_done_nxt     = 1'b0;
    w_pass_nxt     = r_pass;
    w_fail_nxt     = r_fail;
    w_att_nxt      = r_att;
    w_fin_pass_nxt = r_fin_pass;
    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_start_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_start_nxt = 1'b0;
          if (i_req) begin
            w_state_nxt = START;
            w_pass_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
            w_att_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        START: begin
          w_start_nxt = 1'b1;
          w_att_nxt   = sat_inc(r_att, MAX_ATT);
          w_state_nxt = WAIT_GEN;
        end
        WAIT_GEN: begin
          if (w_wdog_hit) begin
            w_start_nxt    = 1'b0;
            w_fin_pass_nxt = 1'b0;
            w_state_nxt    = FINISH;
          end else if (w_gen_done_s) begin
            w_start_nxt = 1'b0;
            w_state_nxt = WAIT_RX;
          end else begin
            w_start_nxt = 1'b1;
          end
        end
        WAIT_RX: begin
          w_start_nxt = 1'b0;
          if (w_wdog_hit) begin
            w_fin_pass_nxt = 1'b0;
            w_state_nxt    = FINISH;
          end else if (i_rx_valid && i_rx_pass) begin
            w_fin_pass_nxt = 1'b1;
            w_state_nxt    = FINISH;
          end else if (i_rx_valid) begin
            if (r_att < MAX_ATT) begin
              w_state_nxt = GAP;
            end else begin
              w_fin_pass_nxt = 1'b0;
              w_state_nxt    = FINISH;
            end
          end else begin
            w_state_nxt = WAIT_RX;
          end
        end
        GAP: begin
          // Wait for the generator to drop done so the next start is a fresh rising edge.
          w_start_nxt = 1'b0;
          if (!w_gen_done_s) begin
            w_state_nxt = START;
          end else begin
            w_state_nxt = GAP;
          end
        end
        FINISH: begin
          w_start_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = r_fin_pass;
          w_fail_nxt  = !r_fin_pass;
          w_state_nxt = IDLE;
        end
        default: begin
          w_start_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_att      <= '0;
      r_fin_pass <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start    <= w_start_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_fail     <= w_fail_nxt;
      r_att      <= w_att_nxt;
      r_fin_pass <= w_fin_pass_nxt;
    end
  end

  assign o_start_clk_training = r_start;
  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_pass               = r_pass;
  assign o_fail               = r_fail;
  assign o_attempt_cnt        = r_att;

endmodule

// File: tb/tb_mb_clk_train_ctrl.sv
// Self-checking bench for mb_clk_train_ctrl: a behavioural clock generator
// and partner receiver react to the DUT; table vectors run full sequences and
// a scoreboard queue holds the expected result of each accepted request.
module tb_mb_clk_train_ctrl;

  localparam int TMO = 16;
`ifdef MB_CLK_TRAIN_TIMEOUT_EN
  localparam int LONG_D = 4;
`else
  localparam int LONG_D = 39;
`endif

  logic       i_sys_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_clk_gen_done = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic       i_rx_pass = 1'b0;
  logic       o_start_clk_training;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic       o_fail;
  logic       o_timeout;
  logic [2:0] o_attempt_cnt;

  always #5 i_sys_clk = ~i_sys_clk;

  mb_clk_train_ctrl #(.MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk            (i_sys_clk),
    .i_rst_n              (i_rst_n),
    .i_req                (i_req),
    .i_abort              (i_abort),
    .i_clk_gen_done       (i_clk_gen_done),
    .i_rx_valid           (i_rx_valid),
    .i_rx_pass            (i_rx_pass),
    .o_start_clk_training (o_start_clk_training),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_pass               (o_pass),
    .o_fail               (o_fail),
    .o_timeout            (o_timeout),
    .o_attempt_cnt        (o_attempt_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment configuration (written by the main sequence only).
  int         cfg_gen_delay = 5;
  bit         cfg_gen_en    = 1'b1;
  int         cfg_rx_delay  = 2;
  logic [2:0] cfg_pattern   = 3'b001;

  // Environment state (written by the environment process only).
  int   start_edges = 0;
  int   done_count  = 0;
  int   attempt_idx = 0;
  logic prev_start  = 1'b0;
  int   gen_cnt     = 0;
  bit   gen_arm     = 1'b0;
  int   rx_cnt      = 0;
  bit   rx_arm      = 1'b0;
  int   hi_cnt      = 0;
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  // Generator + receiver model, sampled 1 time unit after each rising edge.
  always @(posedge i_sys_clk) begin
    #1;
    s2 = s1;
    s1 = i_clk_gen_done;
    i_rx_valid = 1'b0;
    if (!o_busy) begin
      rx_arm      = 1'b0;
      gen_arm     = 1'b0;
      attempt_idx = 0;
    end
    if (rx_arm) begin
      if (rx_cnt == 0) begin
        i_rx_valid = 1'b1;
        i_rx_pass  = (attempt_idx >= 1 && attempt_idx <= 3) ? cfg_pattern[attempt_idx-1] : 1'b0;
        rx_arm     = 1'b0;
      end else begin
        rx_cnt--;
      end
    end
    if (gen_arm) begin
      gen_cnt--;
      if (gen_cnt <= 0) begin
        i_clk_gen_done = 1'b1;
        gen_arm        = 1'b0;
      end
    end
    if (o_done) done_count++;
    if (o_start_clk_training && !prev_start) begin
      start_edges++;
      attempt_idx++;
      hi_cnt = 0;
      check("gen_done_s_low_at_start_rise", {31'd0, s2}, 32'd0);
      if (cfg_gen_en) begin
        gen_cnt = cfg_gen_delay;
        gen_arm = 1'b1;
      end
    end
    if (o_start_clk_training) hi_cnt++;
    if (!o_start_clk_training && prev_start) begin
      if (o_busy && i_clk_gen_done) begin
        check("start_high_len", hi_cnt, cfg_gen_delay + 3);
        rx_cnt = cfg_rx_delay;
        rx_arm = 1'b1;
      end
      i_clk_gen_done = 1'b0;
    end
    prev_start = o_start_clk_training;
  end

  typedef struct {
    string      name;
    logic [2:0] pattern;
    int         gen_delay;
    int         rx_delay;
    logic       exp_pass;
    logic       exp_fail;
    logic [2:0] exp_att;
    int         exp_edges;
  } vec_t;

  vec_t vecs[4];
  vec_t sb_q[$];

  task automatic pulse_req();
    @(negedge i_sys_clk);
    i_req = 1'b1;
    @(negedge i_sys_clk);
    i_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"},   {31'd0, o_start_clk_training}, 32'd0);
    check({tag, "_busy"},    {31'd0, o_busy},    32'd0);
    check({tag, "_done"},    {31'd0, o_done},    32'd0);
    check({tag, "_pass"},    {31'd0, o_pass},    32'd0);
    check({tag, "_fail"},    {31'd0, o_fail},    32'd0);
    check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
    check({tag, "_att"},     {29'd0, o_attempt_cnt}, 32'd0);
  endtask

  initial begin
    int   edges0;
    int   done0;
    int   cyc;
    vec_t ev;

    vecs[0] = '{"pass",    3'b001, LONG_D, 2, 1'b1, 1'b0, 3'd1, 1};
    vecs[1] = '{"retry",   3'b100, 6,      2, 1'b1, 1'b0, 3'd3, 3};
    vecs[2] = '{"exhaust", 3'b000, 6,      0, 1'b0, 1'b1, 3'd3, 3};
    vecs[3] = '{"retry2",  3'b010, 1,      1, 1'b1, 1'b0, 3'd2, 2};

    // Reset state.
    repeat (3) @(negedge i_sys_clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_sys_clk);

    // Table-driven full sequences.
    for (int v = 0; v < 4; v++) begin
      cfg_pattern   = vecs[v].pattern;
      cfg_gen_delay = vecs[v].gen_delay;
      cfg_rx_delay  = vecs[v].rx_delay;
      cfg_gen_en    = 1'b1;
      edges0 = start_edges;
      done0  = done_count;
      sb_q.push_back(vecs[v]);
      pulse_req();
      cyc = 0;
      while (!o_done && cyc < 600) begin
        @(negedge i_sys_clk);
        cyc++;
      end
      ev = sb_q.pop_front();
      check({ev.name, "_done_seen"}, {31'd0, o_done}, 32'd1);
      check({ev.name, "_pass"},    {31'd0, o_pass},    {31'd0, ev.exp_pass});
      check({ev.name, "_fail"},    {31'd0, o_fail},    {31'd0, ev.exp_fail});
      check({ev.name, "_timeout"}, {31'd0, o_timeout}, 32'd0);
      check({ev.name, "_att"},     {29'd0, o_attempt_cnt}, {29'd0, ev.exp_att});
      check({ev.name, "_busy_low"}, {31'd0, o_busy}, 32'd0);
      repeat (6) @(negedge i_sys_clk);
      check({ev.name, "_done_pulses"}, done_count - done0, 32'd1);
      check({ev.name, "_start_edges"}, start_edges - edges0, ev.exp_edges);
      check({ev.name, "_pass_sticky"}, {31'd0, o_pass}, {31'd0, ev.exp_pass});
    end

    // Abort in WAIT_GEN on the same edge the synchronized done arrives.
    cfg_pattern = 3'b001; cfg_gen_delay = 10; cfg_rx_delay = 2; cfg_gen_en = 1'b1;
    edges0 = start_edges;
    done0  = done_count;
    pulse_req();
    cyc = 0;
    while (!i_clk_gen_done && cyc < 100) begin
      @(negedge i_sys_clk);
      cyc++;
    end
    check("abort_gen_done_seen", {31'd0, i_clk_gen_done}, 32'd1);
    repeat (2) @(negedge i_sys_clk);
    i_abort = 1'b1;
    @(negedge i_sys_clk);
    i_abort = 1'b0;
    check("abort_busy",  {31'd0, o_busy}, 32'd0);
    check("abort_start", {31'd0, o_start_clk_training}, 32'd0);
    check("abort_done",  {31'd0, o_done}, 32'd0);
    repeat (20) @(negedge i_sys_clk);
    check("abort_no_done",  done_count - done0, 32'd0);
    check("abort_att",      {29'd0, o_attempt_cnt}, 32'd1);
    check("abort_pass",     {31'd0, o_pass}, 32'd0);
    check("abort_fail",     {31'd0, o_fail}, 32'd0);
    check("abort_edges",    start_edges - edges0, 32'd1);

    // Request while busy is ignored; reset mid-WAIT_RX clears everything.
    cfg_gen_delay = 3; cfg_rx_delay = 50;
    edges0 = start_edges;
    done0  = done_count;
    pulse_req();
    @(negedge i_sys_clk);
    i_req = 1'b1;
    @(negedge i_sys_clk);
    i_req = 1'b0;
    cyc = 0;
    while (o_start_clk_training && cyc < 100) begin
      @(negedge i_sys_clk);
      cyc++;
    end
    repeat (2) @(negedge i_sys_clk);
    check("busyreq_att",   {29'd0, o_attempt_cnt}, 32'd1);
    check("busyreq_edges", start_edges - edges0, 32'd1);
    check("waitrx_busy",   {31'd0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_sys_clk);
    check_all_zero("midrst");
    i_rst_n = 1'b1;
    repeat (60) @(negedge i_sys_clk);
    check("midrst_no_done", done_count - done0, 32'd0);
    check("midrst_idle",    {31'd0, o_busy}, 32'd0);

    // Generator never answers.
    cfg_gen_en = 1'b0; cfg_rx_delay = 2;
    done0 = done_count;
    pulse_req();
`ifdef MB_CLK_TRAIN_TIMEOUT_EN
    cyc = 0;
    while (!o_done && cyc < 200) begin
      @(negedge i_sys_clk);
      cyc++;
    end
    check("timeout_latency", cyc, TMO + 2);
    check("timeout_fail",    {31'd0, o_fail},    32'd1);
    check("timeout_flag",    {31'd0, o_timeout}, 32'd1);
    check("timeout_pass",    {31'd0, o_pass},    32'd0);
    check("timeout_att",     {29'd0, o_attempt_cnt}, 32'd1);
    repeat (4) @(negedge i_sys_clk);
    check("timeout_done_pulses", done_count - done0, 32'd1);
`else
    repeat (40) @(negedge i_sys_clk);
    check("nowdog_busy",    {31'd0, o_busy},    32'd1);
    check("nowdog_timeout", {31'd0, o_timeout}, 32'd0);
    check("nowdog_no_done", done_count - done0, 32'd0);
    i_abort = 1'b1;
    @(negedge i_sys_clk);
    i_abort = 1'b0;
    check("nowdog_abort_idle", {31'd0, o_busy}, 32'd0);
`endif
    cfg_gen_en = 1'b1;
    repeat (3) @(negedge i_sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time bound, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
